// File: rtl/branch_predict_unit_if.sv
// branch_predict_unit_if: IF-side lookup and ID-side resolution bundle for the branch predictor
interface branch_predict_unit_if #(parameter int XLEN = 32);
    logic [XLEN-1:0] pc;
    logic            pred_taken;
    logic [XLEN-1:0] pred_target;
    logic [XLEN-1:0] npc;
    logic            upd_valid;
    logic [XLEN-1:0] upd_pc;
    logic            upd_taken;
    logic [XLEN-1:0] upd_target;
    logic            upd_pred_taken;
    logic [XLEN-1:0] upd_pred_target;
    logic            flush;
    modport master (
        output pc, upd_valid, upd_pc, upd_taken, upd_target, upd_pred_taken, upd_pred_target,
        input  pred_taken, pred_target, npc, flush
    );
    modport slave (
        input  pc, upd_valid, upd_pc, upd_taken, upd_target, upd_pred_taken, upd_pred_target,
        output pred_taken, pred_target, npc, flush
    );
endinterface

// File: rtl/branch_predict_unit.sv
// branch_predict_unit: BTB-based next-PC generator with saturating counters; BPU_PERF_CNT_EN adds perf counters
module branch_predict_unit #(
    parameter int              XLEN        = 32,
    parameter int              ENTRIES     = 64,
    parameter int              CTR_W       = 2,
    parameter logic [XLEN-1:0] MAX_INSADDR = 32'hffff_fff8
) (
    input  logic                  clk,
    input  logic                  rst,
    branch_predict_unit_if.slave  bp
`ifdef BPU_PERF_CNT_EN
    ,
    output logic [31:0]           perf_branches,
    output logic [31:0]           perf_mispredicts
`endif
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = XLEN - IDX_W - 2;
    localparam logic [CTR_W-1:0] CTR_WT  = CTR_W'(1 << (CTR_W - 1));
    localparam logic [CTR_W-1:0] CTR_WNT = CTR_W'((1 << (CTR_W - 1)) - 1);
    localparam logic [CTR_W-1:0] CTR_MAX = '1;

    logic             valid_q [ENTRIES];
    logic [TAG_W-1:0] tag_q   [ENTRIES];
    logic [XLEN-1:0]  tgt_q   [ENTRIES];
    logic [CTR_W-1:0] ctr_q   [ENTRIES];

    logic [IDX_W-1:0] idx, u_idx;
    logic [TAG_W-1:0] tag, u_tag;
    logic             hit, u_hit, mispredict, we;
    logic [XLEN-1:0]  fall, u_fall, redirect;
    logic [CTR_W-1:0] u_ctr, ctr_d;

    assign idx   = bp.pc[IDX_W+1:2];
    assign tag   = bp.pc[XLEN-1:IDX_W+2];
    assign u_idx = bp.upd_pc[IDX_W+1:2];
    assign u_tag = bp.upd_pc[XLEN-1:IDX_W+2];
    assign u_ctr = ctr_q[u_idx];

    // Lookup, misprediction detection and next-PC selection; reset forces a quiet, zero next PC
    always_comb begin
        hit            = !rst && valid_q[idx] && tag_q[idx] == tag;
        u_hit          = valid_q[u_idx] && tag_q[u_idx] == u_tag;
        fall           = bp.pc >= MAX_INSADDR ? bp.pc : bp.pc + XLEN'(4);
        u_fall         = bp.upd_pc >= MAX_INSADDR ? bp.upd_pc : bp.upd_pc + XLEN'(4);
        redirect       = bp.upd_taken ? bp.upd_target : u_fall;
        mispredict     = !rst && bp.upd_valid && ((bp.upd_taken != bp.upd_pred_taken) ||
                         (bp.upd_taken && bp.upd_target != bp.upd_pred_target));
        bp.pred_taken  = hit && ctr_q[idx][CTR_W-1];
        bp.pred_target = hit ? tgt_q[idx] : '0;
        bp.flush       = mispredict;
        bp.npc         = rst ? '0 : mispredict ? redirect : bp.pred_taken ? bp.pred_target : fall;
        we             = bp.upd_valid && (u_hit || bp.upd_taken);
        ctr_d          = !u_hit ? CTR_WT :
                         bp.upd_taken ? (u_ctr == CTR_MAX ? u_ctr : u_ctr + CTR_W'(1)) :
                         (u_ctr == '0 ? u_ctr : u_ctr - CTR_W'(1));
    end

    // Train the resolved entry; a miss only allocates when the branch was taken
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= CTR_WNT;
            end
        end else if (we) begin
            valid_q[u_idx] <= 1'b1;
            ctr_q[u_idx]   <= ctr_d;
            if (bp.upd_taken) begin
                tag_q[u_idx] <= u_tag;
                tgt_q[u_idx] <= bp.upd_target;
            end
        end
    end

`ifdef BPU_PERF_CNT_EN
    logic [31:0] perf_branches_q, perf_mispredicts_q;

    // Count resolved control-flow instructions and mispredictions, wrapping at 2^32
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_branches_q    <= '0;
            perf_mispredicts_q <= '0;
        end else begin
            if (bp.upd_valid) perf_branches_q <= perf_branches_q + 32'd1;
            if (mispredict) perf_mispredicts_q <= perf_mispredicts_q + 32'd1;
        end
    end

    assign perf_branches    = perf_branches_q;
    assign perf_mispredicts = perf_mispredicts_q;
`endif
endmodule
